// File: rtl/bist_pkg.sv
// Shared definitions for the BIST engine: widths, select codes, FSM states, data patterns.
package bist_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;

  localparam logic [3:0] SEL_FILL0 = 4'd0;
  localparam logic [3:0] SEL_M1    = 4'd1;
  localparam logic [3:0] SEL_M2    = 4'd2;
  localparam logic [3:0] SEL_M3    = 4'd3;
  localparam logic [3:0] SEL_M4    = 4'd4;
  localparam logic [3:0] SEL_CBW   = 4'd5;
  localparam logic [3:0] SEL_CBV   = 4'd6;
  localparam logic [3:0] SEL_NONE  = 4'hF;

  localparam logic [DATA_W-1:0] PAT_0 = 4'h0;
  localparam logic [DATA_W-1:0] PAT_F = 4'hF;
  localparam logic [DATA_W-1:0] PAT_5 = 4'h5;
  localparam logic [DATA_W-1:0] PAT_A = 4'hA;

  typedef enum logic [2:0] {IDLE, WR, RD, RW, VR, DONE} state_t;

  function automatic logic [DATA_W-1:0] cb_pat(input logic addr_lsb);
    return addr_lsb ? PAT_A : PAT_5;
  endfunction

endpackage

// File: rtl/sram.sv
// 256 x 4 single-port SRAM with registered read; read-during-write returns old data.
module sram #(
  parameter int ADDR_W = bist_pkg::ADDR_W,
  parameter int DATA_W = bist_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] dat_in,
  output logic [DATA_W-1:0] read_d
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (w_en) mem[addr_in] <= dat_in;
    read_d <= mem[addr_in];
  end

endmodule

// File: rtl/bist_engine_top.sv
// BIST controller: sequences fill, march and checkerboard operations over an external
// SRAM, checks read-back data and reports completion and the first failing address.
module bist_engine_top #(
  parameter int ADDR_W = bist_pkg::ADDR_W,
  parameter int DATA_W = bist_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        select,
  input  logic [DATA_W-1:0] dat_in,
  output logic [DATA_W-1:0] dat_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              w_en,
  output logic              op_done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr
);
  import bist_pkg::*;

  state_t            state, state_n;
  logic [3:0]        last_sel;
  logic [ADDR_W-1:0] addr_n, step_addr, cmp_addr, cmp_addr_n, chk_addr;
  logic [DATA_W-1:0] dat_n, old_pat, new_pat, exp_dat;
  logic              w_en_n, done_n, cmp_valid, cmp_valid_n;
  logic              start, desc, terminal, mismatch;

  always_comb begin
    start     = (select != last_sel);
    desc      = (last_sel == SEL_M3) || (last_sel == SEL_M4);
    step_addr = desc ? addr_out - 1'b1 : addr_out + 1'b1;
    terminal  = desc ? (addr_out == '0) : (addr_out == '1);
    old_pat   = ((last_sel == SEL_M1) || (last_sel == SEL_M3)) ? PAT_0 : PAT_F;
    new_pat   = ((last_sel == SEL_M1) || (last_sel == SEL_M3)) ? PAT_F : PAT_0;
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr_out;
    dat_n       = dat_out;
    w_en_n      = 1'b0;
    done_n      = 1'b0;
    cmp_valid_n = 1'b0;
    cmp_addr_n  = cmp_addr;
    if (start) begin
      // The start edge already drives the first cycle's address and write strobe.
      unique case (select)
        SEL_FILL0, SEL_CBW: begin
          state_n = WR;
          addr_n  = '0;
          w_en_n  = 1'b1;
          dat_n   = (select == SEL_CBW) ? cb_pat(1'b0) : PAT_0;
        end
        SEL_M1, SEL_M2: begin state_n = RD; addr_n = '0; end
        SEL_M3, SEL_M4: begin state_n = RD; addr_n = '1; end
        SEL_CBV:        begin state_n = VR; addr_n = '0; end
        default:        state_n = IDLE;
      endcase
    end else begin
      unique case (state)
        WR: begin
          if (terminal) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            addr_n = step_addr;
            w_en_n = 1'b1;
            dat_n  = (last_sel == SEL_CBW) ? cb_pat(step_addr[0]) : PAT_0;
          end
        end
        RD: begin
          state_n = RW;
          w_en_n  = 1'b1;
          dat_n   = new_pat;
        end
        RW: begin
          if (terminal) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RD;
            addr_n  = step_addr;
          end
        end
        VR: begin
          cmp_valid_n = 1'b1;
          cmp_addr_n  = addr_out;
          if (terminal) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            addr_n = step_addr;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // March compares land in the write cycle; verify compares trail the read by one cycle.
  always_comb begin
    exp_dat  = (state == RW) ? old_pat : cb_pat(cmp_addr[0]);
    chk_addr = (state == RW) ? addr_out : cmp_addr;
    mismatch = ((state == RW) || cmp_valid) && (dat_in != exp_dat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_sel  <= SEL_NONE;
      addr_out  <= '0;
      dat_out   <= '0;
      w_en      <= 1'b0;
      op_done   <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
    end else begin
      state     <= state_n;
      last_sel  <= select;
      addr_out  <= addr_n;
      dat_out   <= dat_n;
      w_en      <= w_en_n;
      op_done   <= done_n;
      cmp_valid <= cmp_valid_n;
      cmp_addr  <= cmp_addr_n;
      if (mismatch) begin
        fail <= 1'b1;
        if (!fail) fail_addr <= chk_addr;
      end
    end
  end

endmodule

// File: tb/tb_bist_engine_top.sv
// Self-checking bench: engine plus SRAM against a cycle-level model of each operation.
module tb_bist_engine_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] select, rd_data, dat_out;
  logic [7:0] addr_out, fail_addr;
  logic       w_en, op_done, fail;

  logic       ov, ov_we;
  logic [7:0] ov_addr;
  logic [3:0] ov_dat;
  logic       s_we;
  logic [7:0] s_addr;
  logic [3:0] s_dat;

  assign s_we   = ov ? ov_we   : w_en;
  assign s_addr = ov ? ov_addr : addr_out;
  assign s_dat  = ov ? ov_dat  : dat_out;

  always #5 clk = ~clk;

  bist_engine_top #(.ADDR_W(8), .DATA_W(4)) dut (
    .clk(clk), .rst(rst), .select(select), .dat_in(rd_data),
    .dat_out(dat_out), .addr_out(addr_out), .w_en(w_en),
    .op_done(op_done), .fail(fail), .fail_addr(fail_addr)
  );

  sram #(.ADDR_W(8), .DATA_W(4)) u_sram (
    .clk(clk), .w_en(s_we), .addr_in(s_addr), .dat_in(s_dat), .read_d(rd_data)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          mem_m [256];
  int          fail_m, fail_addr_m, last_addr_m, last_dat_m, last_sel_m;

  function automatic int cb(input int a);
    return (a % 2 == 1) ? 'hA : 'h5;
  endfunction

  function automatic int full_len(input int code);
    return (code >= 1 && code <= 4) ? 513 : 257;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fail_m = 0; fail_addr_m = 0; last_addr_m = 0; last_dat_m = 0; last_sel_m = 'hF;
  endtask

  // Called at a negedge; runs ncyc cycles of the operation (0 = to completion).
  task automatic run_op(input int code, input int ncyc);
    int full, n, a, d, ca, ce, k;
    bit we, done, cmp;
    full = full_len(code);
    n = (ncyc == 0) ? full : ncyc;
    select = 4'(code);
    last_sel_m = code;
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      done = (t == full);
      we = 0; cmp = 0; a = 0; d = 0; ca = 0; ce = 0;
      if (code == 0 || code == 5) begin
        a = t - 1; we = !done; d = (code == 0) ? 0 : cb(a);
      end else if (code == 6) begin
        a = t - 1;
        if (t >= 2) begin cmp = 1; ca = t - 2; ce = cb(ca); end
      end else begin
        k = (t - 1) / 2;
        a = (code <= 2) ? k : 255 - k;
        if (t % 2 == 0 && !done) begin
          we = 1; cmp = 1; ca = a;
          d  = (code % 2 == 1) ? 'hF : 'h0;
          ce = (code % 2 == 1) ? 'h0 : 'hF;
        end
      end
      chk("op_done", 32'(op_done), 32'(done));
      chk("w_en", 32'(w_en), 32'(we));
      chk("addr_out", 32'(addr_out), done ? last_addr_m : a);
      if (we) chk("dat_out", 32'(dat_out), d);
      if (cmp && mem_m[ca] != ce) begin
        if (fail_m == 0) fail_addr_m = ca;
        fail_m = 1;
      end
      if (we) begin mem_m[a] = d; last_dat_m = d; end
      if (!done) last_addr_m = a;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_w_en", 32'(w_en), 0);
      chk("idle_op_done", 32'(op_done), 0);
      chk("idle_addr", 32'(addr_out), last_addr_m);
      chk("idle_dat", 32'(dat_out), last_dat_m);
    end
    chk("fail", 32'(fail), fail_m);
    chk("fail_addr", 32'(fail_addr), fail_addr_m);
  endtask

  task automatic run_reserved(input int code, input int n);
    select = 4'(code);
    last_sel_m = code;
    idle(n);
  endtask

  task automatic inject(input int a, input int d);
    ov = 1; ov_we = 1; ov_addr = 8'(a); ov_dat = 4'(d);
    @(negedge clk);
    ov = 0; ov_we = 0;
    mem_m[a] = d;
  endtask

  initial begin
    int code, len;
    rst = 1; select = 4'hF; ov = 0; ov_we = 0; ov_addr = '0; ov_dat = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr_out), 0);
    chk("rst_dat", 32'(dat_out), 0);
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_op_done", 32'(op_done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_fail_addr", 32'(fail_addr), 0);
    rst = 0;

    for (int c = 0; c <= 6; c++) begin
      run_op(c, 0);
      idle(2);
    end
    chk("seq_fail", 32'(fail), 0);

    run_op(0, 0); idle(2);
    inject('h37, 'h2);
    run_op(1, 0); idle(2);
    chk("fault_fail", 32'(fail), 1);
    chk("fault_fail_addr", 32'(fail_addr), 'h37);

    run_op(2, 0); idle(2);
    run_op(1, 100);
    run_op(3, 0); idle(3);

    run_op(4, 77);
    rst = 1;
    @(negedge clk);
    model_reset();
    chk("mid_rst_w_en", 32'(w_en), 0);
    chk("mid_rst_fail", 32'(fail), 0);
    chk("mid_rst_op_done", 32'(op_done), 0);
    chk("mid_rst_addr", 32'(addr_out), 0);
    rst = 0;
    run_op(4, 0); idle(2);

    run_reserved(7, 600);

    for (int i = 0; i < 8; i++) begin
      code = int'($urandom_range(0, 7));
      if (code == last_sel_m) code = (code + 1) % 8;
      if (code == 7) begin
        run_reserved(7, int'($urandom_range(3, 20)));
      end else if (i < 7 && $urandom_range(0, 1) == 1) begin
        len = int'($urandom_range(1, full_len(code) - 1));
        run_op(code, len);
      end else begin
        run_op(code, 0);
        idle(2);
        if ($urandom_range(0, 2) == 0)
          inject(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
      end
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bist_engine_top.md
# bist_engine_top

Memory built-in self-test controller for a 256 x 4 single-port SRAM. A 4-bit `select` code picks one of seven test operations (fill, four march elements, checkerboard write/verify). The engine drives the SRAM's address, write data and write enable, checks read-back data, and pulses `op_done` when the operation finishes. It sits between the test sequencer (which issues `select`) and the separate `sram` block.

## Interface
- `ADDR_W`, 8, address width (256 words)
- `DATA_W`, 4, data width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `select`  in  4  operation code
- `dat_in`  in  4  SRAM read data (`read_d`)
- `dat_out`  out  4  SRAM write data
- `addr_out`  out  8  SRAM address
- `w_en`  out  1  SRAM write enable
- `op_done`  out  1  one-cycle completion pulse
- `fail`  out  1  sticky mismatch flag
- `fail_addr`  out  8  address of the first mismatch

One clock; reset is synchronous and active-high.

## Operation
- Select codes; CB(a) is 4'b0101 when a[0]=0 and 4'b1010 when a[0]=1:
  - 0: fill, ascending, w0 (write 4'h0)
  - 1: ascending, r0 then w1 (4'hF)
  - 2: ascending, r1 then w0
  - 3: descending, r0 then w1
  - 4: descending, r1 then w0
  - 5: ascending, write CB(a)
  - 6: ascending, read and verify CB(a)
  - 7–15: reserved. The engine idles and never asserts `op_done`.
- Start: the registered copy `last_sel` resets to 4'hF. On any edge where `select != last_sel`, the engine latches `select` into `last_sel` and starts that operation.
- Abort: a `select` change during an operation aborts it and starts the new one at the next edge. A write already in progress is not completed.
- Idle: once done, the engine stays idle until `select` changes. While idle, `w_en`=0 and `addr_out`/`dat_out` hold their last values.
- FSM states: IDLE, WR (write-only sweep), RD (march read phase), RW (march write phase), VR (verify sweep), DONE (single cycle, asserts `op_done`), then back to IDLE.
- Compare: a mismatch between `dat_in` and the expected value sets `fail`. `fail_addr` is captured only on the first mismatch since reset. `fail` clears only on `rst`.
- Address counter: 8-bit up/down. Ascending runs 0..255; descending runs 255..0. Completion is detected at the terminal address, with no wrap into a second pass.

## Timing
- All outputs are registered. Reset values: `dat_out`=0, `addr_out`=0, `w_en`=0, `op_done`=0, `fail`=0, `fail_addr`=0, state IDLE.
- The SRAM has a 1-cycle synchronous read: data for the address in cycle n appears on `dat_in` in cycle n+1.
- Edge E0 latches `select`. Cycle 1 is the first cycle after E0.
- Codes 0 and 5: one write per cycle in cycles 1..256 (`w_en`=1). `op_done` is high in cycle 257.
- Codes 1–4: address a uses two cycles.
  - Cycle 2k+1: `addr_out`=a, `w_en`=0 (read).
  - Cycle 2k+2: `addr_out`=a, `w_en`=1, new data on `dat_out`; `dat_in` is compared against the old expected value in this same cycle.
  - `op_done` is high in cycle 513.
- Code 6: reads in cycles 1..256 with `w_en`=0. Compares happen in cycles 2..257. `op_done` is high in cycle 257, alongside the last compare.
- `op_done` is high for exactly one cycle per completed operation and never for an aborted one.
- `rst` mid-operation: the engine returns to IDLE next cycle with `w_en`=0. Because `last_sel` is reset, any `select` other than 4'hF restarts the engine.

## Structure
- Shared package `bist_pkg`:
  - `ADDR_W`, `DATA_W`
  - select code constants
  - FSM state enum
  - pattern constants: 4'h0, 4'hF, 4'h5, 4'hA
- Sub-module `sram` (separate block, instantiated beside the engine, not inside it):
  - 256 x 4
  - writes `dat_in` at `addr_in` on the clock edge when `w_en`=1
  - `read_d` is registered from `mem[addr_in]` every cycle; a read and write to the same address return the old data
  - no memory reset
- Inside the engine: a single FSM plus an address counter and compare logic. No further sub-modules.

## Test plan
- Reset, then `select`=0 -> addresses 0..255 written with 4'h0; one `op_done` pulse in cycle 257; `fail`=0.
- Sequence 0, 1, 2, 3, 4, 5, 6, each after the previous `op_done` -> every `op_done` at the specified cycle; `fail`=0 throughout; memory holds CB(a) at the end.
- Run 0, then force `mem[0x37]`=4'h2 in `sram`, then `select`=1 -> `fail`=1 and `fail_addr`=0x37; the operation still completes with `op_done`.
- `select` changes from 1 to 3 at cycle 100 of op 1 -> no `op_done` for op 1; op 3 starts at `addr_out`=255 and completes 513 cycles later.
- `rst` asserted mid-op 4 -> next cycle `w_en`=0, `fail`=0, state IDLE; holding `select`=4 restarts op 4 after reset.
- `select`=7 -> no SRAM writes and `op_done` stays 0 indefinitely.
